// File: rtl/bus_pkg.sv
// Shared system-bus types: transfer size/type, latched transaction and interconnect FSM states.
package bus_pkg;
   localparam int BUS_DW = 32;

   typedef enum logic [1:0] {
      TSIZE_BYTE = 2'd0,
      TSIZE_HALF = 2'd1,
      TSIZE_WORD = 2'd2
   } tsize_e;

   typedef enum logic {
      TTYPE_READ  = 1'b0,
      TTYPE_WRITE = 1'b1
   } ttype_e;

   typedef struct packed {
      logic [BUS_DW-1:0] addr;
      logic [BUS_DW-1:0] wdata;
      tsize_e            tsize;
      ttype_e            ttype;
   } transaction;

   typedef enum logic [1:0] {
      IDLE,
      OWNED,
      ACTIVE,
      RESP
   } ic_state_e;
endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority starts at the requester after the last winner.
// Pointer moves only when advance is asserted with a pending request; no backpressure of its own.
module bus_rr_arbiter #(
   parameter int N = 2
) (
   input  logic         bclk,
   input  logic         brst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   int            idx;

   // Scan from farthest to nearest so the requester closest to ptr is written last and wins.
   always_comb begin
      gnt = '0;
      win = '0;
      idx = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            win      = PW'(idx);
         end
      end
   end

   always_ff @(posedge bclk) begin
      if (brst) begin
         ptr <= '0;
      end else if (advance && (|req)) begin
         ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
      end
   end
endmodule

// File: rtl/bus_interconnect.sv
// N-master x M-slave shared-bus interconnect: round-robin ownership, address decode, per-transaction timeout.
// Grant 1 cycle after request; slave select 1 cycle after start; master done 1 cycle after slave done or timeout.
module bus_interconnect
   import bus_pkg::*;
#(
   parameter int                        N_MASTERS  = 2,
   parameter int                        N_SLAVES   = 4,
   parameter int unsigned               TIMEOUT    = 255,
   parameter logic [N_SLAVES-1:0][31:0] SLAVE_BASE = {N_SLAVES{32'h0}},
   parameter logic [N_SLAVES-1:0][31:0] SLAVE_MASK = {N_SLAVES{32'h0}}
) (
   input  logic                          bclk,
   input  logic                          brst,
   input  logic [N_MASTERS-1:0]          m_breq,
   input  logic [N_MASTERS-1:0]          m_bstart,
   input  logic [N_MASTERS-1:0][31:0]    m_addr,
   input  logic [N_MASTERS-1:0][31:0]    m_wdata,
   input  logic [N_MASTERS-1:0][1:0]     m_tsize,
   input  logic [N_MASTERS-1:0]          m_ttype,
   output logic [N_MASTERS-1:0]          m_bgnt,
   output logic [N_MASTERS-1:0]          m_bdone,
   output logic [N_MASTERS-1:0]          m_berror,
   output logic [N_MASTERS-1:0][31:0]    m_rdata,
   output logic [N_SLAVES-1:0]           s_ss,
   output logic [N_SLAVES-1:0]           s_bstart,
   output logic [N_SLAVES-1:0][31:0]     s_addr,
   output logic [N_SLAVES-1:0][31:0]     s_wdata,
   output logic [N_SLAVES-1:0][1:0]      s_tsize,
   output logic [N_SLAVES-1:0]           s_ttype,
   input  logic [N_SLAVES-1:0]           s_bdone,
   input  logic [N_SLAVES-1:0]           s_berror,
   input  logic [N_SLAVES-1:0][31:0]     s_rdata
);
   localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   ic_state_e            state;
   transaction           txn;
   logic [MW-1:0]        owner;
   logic [SW-1:0]        sel;
   logic [15:0]          cnt;
   logic [31:0]          resp_rdata;

   logic [N_MASTERS-1:0] arb_gnt;
   logic [MW-1:0]        arb_idx;
   logic                 dec_hit;
   logic [SW-1:0]        dec_idx;
   logic [N_SLAVES-1:0]  dec_oh;

   bus_rr_arbiter #(.N(N_MASTERS)) u_arb (
      .bclk    (bclk),
      .brst    (brst),
      .req     (m_breq),
      .advance (state == IDLE),
      .gnt     (arb_gnt)
   );

   always_comb begin
      arb_idx = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (arb_gnt[i]) arb_idx = MW'(i);
      end
   end

   // Descending scan: the lowest matching slave index is written last and wins.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      dec_oh  = '0;
      for (int k = N_SLAVES - 1; k >= 0; k--) begin
         if ((m_addr[owner] & SLAVE_MASK[k]) == SLAVE_BASE[k]) begin
            dec_hit    = 1'b1;
            dec_idx    = SW'(k);
            dec_oh     = '0;
            dec_oh[k]  = 1'b1;
         end
      end
   end

   always_ff @(posedge bclk) begin
      if (brst) begin
         state      <= IDLE;
         txn        <= '0;
         owner      <= '0;
         sel        <= '0;
         cnt        <= '0;
         resp_rdata <= '0;
         m_bgnt     <= '0;
         m_bdone    <= '0;
         m_berror   <= '0;
         s_ss       <= '0;
         s_bstart   <= '0;
      end else begin
         m_bdone  <= '0;
         m_berror <= '0;
         s_bstart <= '0;
         case (state)
            IDLE: begin
               if (|m_breq) begin
                  state  <= OWNED;
                  owner  <= arb_idx;
                  m_bgnt <= arb_gnt;
               end
            end
            OWNED: begin
               if (m_bstart[owner]) begin
                  txn <= '{addr:  m_addr[owner],
                           wdata: m_wdata[owner],
                           tsize: tsize_e'(m_tsize[owner]),
                           ttype: ttype_e'(m_ttype[owner])};
                  if (dec_hit) begin
                     state    <= ACTIVE;
                     sel      <= dec_idx;
                     s_ss     <= dec_oh;
                     s_bstart <= dec_oh;
                     cnt      <= '0;
                  end else begin
                     state      <= RESP;
                     m_bdone    <= m_bgnt;
                     m_berror   <= m_bgnt;
                     resp_rdata <= '0;
                  end
               end else if (!m_breq[owner]) begin
                  state  <= IDLE;
                  m_bgnt <= '0;
               end
            end
            ACTIVE: begin
               // A slave response in the expiry cycle takes precedence over the timeout.
               if (s_bdone[sel]) begin
                  state      <= RESP;
                  s_ss       <= '0;
                  m_bdone    <= m_bgnt;
                  m_berror   <= s_berror[sel] ? m_bgnt : '0;
                  resp_rdata <= s_rdata[sel];
               end else if (cnt == 16'(TIMEOUT)) begin
                  state      <= RESP;
                  s_ss       <= '0;
                  m_bdone    <= m_bgnt;
                  m_berror   <= m_bgnt;
                  resp_rdata <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               if (m_breq[owner]) begin
                  state <= OWNED;
               end else begin
                  state  <= IDLE;
                  m_bgnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      for (int k = 0; k < N_SLAVES; k++) begin
         s_addr[k]  = s_ss[k] ? txn.addr : '0;
         s_wdata[k] = s_ss[k] ? txn.wdata : '0;
         s_tsize[k] = s_ss[k] ? 2'(txn.tsize) : 2'b00;
         s_ttype[k] = s_ss[k] && (txn.ttype == TTYPE_WRITE);
      end
      for (int i = 0; i < N_MASTERS; i++) begin
         m_rdata[i] = m_bdone[i] ? resp_rdata : '0;
      end
   end
endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: 2 masters, 4 slaves decoded on the top nibble, TIMEOUT=4.
module tb_bus_interconnect;
   import bus_pkg::*;

   logic             bclk;
   logic             brst;
   logic [1:0]       m_breq;
   logic [1:0]       m_bstart;
   logic [1:0][31:0] m_addr;
   logic [1:0][31:0] m_wdata;
   logic [1:0][1:0]  m_tsize;
   logic [1:0]       m_ttype;
   logic [1:0]       m_bgnt;
   logic [1:0]       m_bdone;
   logic [1:0]       m_berror;
   logic [1:0][31:0] m_rdata;
   logic [3:0]       s_ss;
   logic [3:0]       s_bstart;
   logic [3:0][31:0] s_addr;
   logic [3:0][31:0] s_wdata;
   logic [3:0][1:0]  s_tsize;
   logic [3:0]       s_ttype;
   logic [3:0]       s_bdone;
   logic [3:0]       s_berror;
   logic [3:0][31:0] s_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   bus_interconnect #(
      .N_MASTERS  (2),
      .N_SLAVES   (4),
      .TIMEOUT    (4),
      .SLAVE_BASE ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
      .SLAVE_MASK ({4{32'hF000_0000}})
   ) dut (
      .bclk     (bclk),
      .brst     (brst),
      .m_breq   (m_breq),
      .m_bstart (m_bstart),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_tsize  (m_tsize),
      .m_ttype  (m_ttype),
      .m_bgnt   (m_bgnt),
      .m_bdone  (m_bdone),
      .m_berror (m_berror),
      .m_rdata  (m_rdata),
      .s_ss     (s_ss),
      .s_bstart (s_bstart),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_tsize  (s_tsize),
      .s_ttype  (s_ttype),
      .s_bdone  (s_bdone),
      .s_berror (s_berror),
      .s_rdata  (s_rdata)
   );

   initial bclk = 1'b0;
   always #5 bclk = ~bclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge bclk);
      #1;
   endtask

   task automatic test_reset();
      brst = 1'b1;
      tick();
      tick();
      n_tests++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL reset_bgnt: got %b want 00", m_bgnt); end
      n_tests++; if (m_bdone !== 2'b00) begin n_fail++; $display("FAIL reset_bdone: got %b want 00", m_bdone); end
      n_tests++; if (m_berror !== 2'b00) begin n_fail++; $display("FAIL reset_berror: got %b want 00", m_berror); end
      n_tests++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL reset_ss: got %b want 0000", s_ss); end
      n_tests++; if (s_bstart !== 4'b0000) begin n_fail++; $display("FAIL reset_sbstart: got %b want 0000", s_bstart); end
      n_tests++; if (m_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
      brst = 1'b0;
   endtask

   task automatic test_write();
      m_breq = 2'b01;
      tick();
      n_tests++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", m_bgnt); end
      m_bstart    = 2'b01;
      m_addr[0]   = 32'h1000_0004;
      m_wdata[0]  = 32'hDEAD_BEEF;
      m_tsize[0]  = TSIZE_WORD;
      m_ttype[0]  = TTYPE_WRITE;
      tick();
      m_bstart = 2'b00;
      n_tests++; if (s_ss !== 4'b0010) begin n_fail++; $display("FAIL wr_ss: got %b want 0010", s_ss); end
      n_tests++; if (s_bstart !== 4'b0010) begin n_fail++; $display("FAIL wr_sbstart: got %b want 0010", s_bstart); end
      n_tests++; if (s_addr[1] !== 32'h1000_0004) begin n_fail++; $display("FAIL wr_addr: got %h want 10000004", s_addr[1]); end
      n_tests++; if (s_wdata[1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeef", s_wdata[1]); end
      n_tests++; if (s_tsize[1] !== 2'd2) begin n_fail++; $display("FAIL wr_tsize: got %0d want 2", s_tsize[1]); end
      n_tests++; if (s_ttype[1] !== 1'b1) begin n_fail++; $display("FAIL wr_ttype: got %b want 1", s_ttype[1]); end
      n_tests++; if (s_addr[0] !== 32'h0) begin n_fail++; $display("FAIL wr_unsel_addr: got %h want 0", s_addr[0]); end
      tick();
      n_tests++; if (s_bstart !== 4'b0000) begin n_fail++; $display("FAIL wr_sbstart_pulse: got %b want 0000", s_bstart); end
      n_tests++; if (s_ss !== 4'b0010) begin n_fail++; $display("FAIL wr_ss_held: got %b want 0010", s_ss); end
      tick();
      s_bdone    = 4'b0010;
      s_rdata[1] = 32'h1234_5678;
      tick();
      s_bdone = 4'b0000;
      n_tests++; if (m_bdone !== 2'b01) begin n_fail++; $display("FAIL wr_bdone: got %b want 01", m_bdone); end
      n_tests++; if (m_berror !== 2'b00) begin n_fail++; $display("FAIL wr_berror: got %b want 00", m_berror); end
      n_tests++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL wr_ss_release: got %b want 0000", s_ss); end
   endtask

   // Issued in the cycle right after the previous m_bdone (back-to-back).
   task automatic test_decode_error();
      tick();
      m_bstart   = 2'b01;
      m_addr[0]  = 32'hF000_0000;
      m_ttype[0] = TTYPE_READ;
      tick();
      m_bstart = 2'b00;
      n_tests++; if (m_bdone !== 2'b01) begin n_fail++; $display("FAIL dec_bdone: got %b want 01", m_bdone); end
      n_tests++; if (m_berror !== 2'b01) begin n_fail++; $display("FAIL dec_berror: got %b want 01", m_berror); end
      n_tests++; if (m_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL dec_rdata: got %h want 0", m_rdata[0]); end
      n_tests++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL dec_ss: got %b want 0000", s_ss); end
      n_tests++; if (s_bstart !== 4'b0000) begin n_fail++; $display("FAIL dec_sbstart: got %b want 0000", s_bstart); end
      tick();
      n_tests++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL dec_ss_after: got %b want 0000", s_ss); end
      n_tests++; if (m_bdone !== 2'b00) begin n_fail++; $display("FAIL dec_bdone_pulse: got %b want 00", m_bdone); end
   endtask

   task automatic test_timeout();
      m_bstart  = 2'b01;
      m_addr[0] = 32'h2000_0010;
      tick();
      m_bstart = 2'b00;
      n_tests++; if (s_ss !== 4'b0100) begin n_fail++; $display("FAIL to_ss: got %b want 0100", s_ss); end
      for (int c = 2; c <= 5; c++) begin
         tick();
         n_tests++; if (m_bdone !== 2'b00) begin n_fail++; $display("FAIL to_early_bdone: cycle t+%0d got %b want 00", c, m_bdone); end
      end
      tick();
      n_tests++; if (m_bdone !== 2'b01) begin n_fail++; $display("FAIL to_bdone: got %b want 01", m_bdone); end
      n_tests++; if (m_berror !== 2'b01) begin n_fail++; $display("FAIL to_berror: got %b want 01", m_berror); end
      n_tests++; if (m_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", m_rdata[0]); end
      n_tests++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL to_ss_release: got %b want 0000", s_ss); end
      tick();
      tick();
      s_bdone    = 4'b0100;
      s_rdata[2] = 32'hBAD0_BAD0;
      tick();
      s_bdone = 4'b0000;
      n_tests++; if (m_bdone !== 2'b00) begin n_fail++; $display("FAIL to_late_bdone: got %b want 00", m_bdone); end
      n_tests++; if (m_berror !== 2'b00) begin n_fail++; $display("FAIL to_late_berror: got %b want 00", m_berror); end
   endtask

   task automatic test_timeout_race();
      m_bstart  = 2'b01;
      m_addr[0] = 32'h3000_0000;
      tick();
      m_bstart = 2'b00;
      tick();
      tick();
      tick();
      tick();
      s_bdone    = 4'b1000;
      s_berror   = 4'b0000;
      s_rdata[3] = 32'h0000_00A5;
      tick();
      s_bdone = 4'b0000;
      n_tests++; if (m_bdone !== 2'b01) begin n_fail++; $display("FAIL race_bdone: got %b want 01", m_bdone); end
      n_tests++; if (m_berror !== 2'b00) begin n_fail++; $display("FAIL race_berror: got %b want 00", m_berror); end
      n_tests++; if (m_rdata[0] !== 32'h0000_00A5) begin n_fail++; $display("FAIL race_rdata: got %h want 000000a5", m_rdata[0]); end
      m_breq = 2'b00;
      tick();
      n_tests++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL race_release: got %b want 00", m_bgnt); end
   endtask

   task automatic test_alternate();
      logic [1:0] exp_oh;
      int         o;
      brst = 1'b1;
      tick();
      brst   = 1'b0;
      m_breq = 2'b11;
      for (int r = 0; r < 4; r++) begin
         exp_oh = 2'(1 << (r % 2));
         o      = 1 - (r % 2);
         tick();
         n_tests++; if (m_bgnt !== exp_oh) begin n_fail++; $display("FAIL alt_grant: round %0d got %b want %b", r, m_bgnt, exp_oh); end
         m_addr[o]       = 32'h0000_0000;
         m_addr[r % 2]   = 32'h1000_0000;
         m_bstart        = 2'(1 << o);
         tick();
         m_bstart = 2'b00;
         n_tests++; if (s_ss !== 4'b0000 || m_bdone !== 2'b00) begin n_fail++; $display("FAIL alt_ignore: round %0d ss %b bdone %b want 0000/00", r, s_ss, m_bdone); end
         m_bstart = exp_oh;
         tick();
         m_bstart = 2'b00;
         n_tests++; if (s_ss !== 4'b0010) begin n_fail++; $display("FAIL alt_ss: round %0d got %b want 0010", r, s_ss); end
         s_bdone    = 4'b0010;
         s_rdata[1] = 32'h100 + 32'(r);
         tick();
         s_bdone = 4'b0000;
         n_tests++; if (m_bdone !== exp_oh) begin n_fail++; $display("FAIL alt_bdone: round %0d got %b want %b", r, m_bdone, exp_oh); end
         n_tests++; if (m_rdata[r % 2] !== 32'h100 + 32'(r)) begin n_fail++; $display("FAIL alt_rdata: round %0d got %h want %h", r, m_rdata[r % 2], 32'h100 + 32'(r)); end
         n_tests++; if (m_rdata[o] !== 32'h0) begin n_fail++; $display("FAIL alt_rdata_other: round %0d got %h want 0", r, m_rdata[o]); end
         m_breq[r % 2] = 1'b0;
         tick();
         n_tests++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL alt_handover: round %0d got %b want 00", r, m_bgnt); end
         m_breq[r % 2] = 1'b1;
      end
      m_breq = 2'b00;
      tick();
   endtask

   task automatic test_reset_active();
      m_breq = 2'b01;
      tick();
      m_bstart  = 2'b01;
      m_addr[0] = 32'h1000_0000;
      tick();
      m_bstart = 2'b00;
      n_tests++; if (s_ss !== 4'b0010) begin n_fail++; $display("FAIL rst_act_ss: got %b want 0010", s_ss); end
      brst   = 1'b1;
      m_breq = 2'b00;
      tick();
      n_tests++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL rst_act_bgnt: got %b want 00", m_bgnt); end
      n_tests++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL rst_act_ss_drop: got %b want 0000", s_ss); end
      n_tests++; if (s_addr[1] !== 32'h0) begin n_fail++; $display("FAIL rst_act_addr: got %h want 0", s_addr[1]); end
      n_tests++; if (m_bdone !== 2'b00 || s_bstart !== 4'b0000) begin n_fail++; $display("FAIL rst_act_pulses: bdone %b sbstart %b want 00/0000", m_bdone, s_bstart); end
      brst    = 1'b0;
      m_breq  = 2'b10;
      s_bdone = 4'b0010;
      tick();
      s_bdone = 4'b0000;
      n_tests++; if (m_bgnt !== 2'b10) begin n_fail++; $display("FAIL rst_m1_grant: got %b want 10", m_bgnt); end
      n_tests++; if (m_bdone !== 2'b00) begin n_fail++; $display("FAIL rst_stale_bdone: got %b want 00", m_bdone); end
      tick();
      n_tests++; if (m_bdone !== 2'b00) begin n_fail++; $display("FAIL rst_stale_bdone2: got %b want 00", m_bdone); end
   endtask

   initial begin
      brst     = 1'b1;
      m_breq   = '0;
      m_bstart = '0;
      m_addr   = '0;
      m_wdata  = '0;
      m_tsize  = '0;
      m_ttype  = '0;
      s_bdone  = '0;
      s_berror = '0;
      s_rdata  = '0;
      test_reset();
      test_write();
      test_decode_error();
      test_timeout();
      test_timeout_race();
      test_alternate();
      test_reset_active();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_interconnect.md
# bus_interconnect

Parametrised N-master × M-slave interconnect for the shared system bus, implementing the `ic` side of both bus interfaces. Masters request ownership, are granted round-robin, and issue single transactions that are address-decoded and routed to one slave. Replaces point-to-point master/slave wiring. Adds three behaviours:
- explicit read/write type
- decode-error response
- per-transaction slave timeout

## Interface
Parameters:
- `N_MASTERS`, 2: number of master ports, 1–8.
- `N_SLAVES`, 4: number of slave ports, 1–16.
- `TIMEOUT`, 255: max cycles waited for slave `bdone`, 1–65535.
- `SLAVE_BASE`, `{N_SLAVES{32'h0}}`: packed `N_SLAVES`×32 base addresses.
- `SLAVE_MASK`, `{N_SLAVES{32'h0}}`: packed `N_SLAVES`×32 decode masks.

Ports (`m_*` are packed per master, `s_*` are packed per slave):
- `bclk`  in  1  bus clock; all logic on rising edge.
- `brst`  in  1  synchronous, active-high reset.
- `m_breq`  in  N_MASTERS  ownership request, held for duration of ownership.
- `m_bstart`  in  N_MASTERS  one-cycle transaction start.
- `m_addr`, `m_wdata`  in  N_MASTERS×32  address and write data.
- `m_tsize`  in  N_MASTERS×2  `tsize_e`.
- `m_ttype`  in  N_MASTERS  `ttype_e`.
- `m_bgnt`  out  N_MASTERS  one-hot ownership grant.
- `m_bdone`, `m_berror`  out  N_MASTERS  one-cycle completion and error.
- `m_rdata`  out  N_MASTERS×32  read data, valid with `m_bdone`.
- `s_ss`  out  N_SLAVES  one-hot slave select.
- `s_bstart`  out  N_SLAVES  one-cycle start.
- `s_addr`, `s_wdata`  out  N_SLAVES×32; `s_tsize`  out  N_SLAVES×2; `s_ttype`  out  N_SLAVES.
- `s_bdone`, `s_berror`  in  N_SLAVES; `s_rdata`  in  N_SLAVES×32.

## Operation
- FSM states: `IDLE`, `OWNED`, `ACTIVE`, `RESP`.
- `IDLE`: any `m_breq` → pick the winner round-robin, starting from last owner+1; go to `OWNED`; the winner's `m_bgnt` rises next cycle.
- `OWNED`:
  - Owner's `m_bstart`=1 → latch addr/wdata/tsize/ttype and decode.
  - Slave k matches when `(addr & SLAVE_MASK[k]) == SLAVE_BASE[k]`; the lowest matching k wins.
  - Match → `ACTIVE`. No match → `RESP` with error.
  - Owner's `m_breq`=0 with no `m_bstart` → `IDLE`; `m_bgnt` drops next cycle.
- `ACTIVE`:
  - `s_ss[k]` is held and the latched fields drive slave k.
  - Timeout counter counts cycles from entry.
  - `s_bdone[k]` → capture `s_rdata`/`s_berror` → `RESP`.
  - Counter reaches `TIMEOUT` with no `s_bdone` → `RESP`, `berror`=1, `rdata`=0.
- `RESP`: one-cycle `m_bdone` to the owner, with `m_rdata`/`m_berror`. Next state is `OWNED` if owner `m_breq`=1, else `IDLE`.
- Unused `s_*` outputs and non-owner `m_*` outputs are 0. `s_addr`/`s_wdata`/`s_tsize`/`s_ttype` are nonzero only on the selected slave.
- Ignored inputs:
  - `m_bstart` from a non-owner.
  - `m_bstart` while in `ACTIVE` or `RESP`.
  - `s_bdone` from an unselected slave, or outside `ACTIVE`.
- Dropping `m_breq` during `ACTIVE` does not abort; the response is still delivered, then ownership is released.
- `TIMEOUT` expiry and `s_bdone` in the same cycle: the slave response wins, no timeout error.

## Timing
- Reset (`brst`=1 at an edge): all outputs 0, state `IDLE`, counter 0, round-robin pointer → master 0 has priority.
- Reset mid-transaction: `s_ss` drops at the next edge; no `m_bdone` is issued.
- Grant latency: `m_breq` at cycle t in `IDLE` → `m_bgnt` at t+1.
- Owner `m_bstart` at t:
  - Decoded: `s_ss`/`s_bstart` at t+1, with `s_bstart` for one cycle and `s_ss` held until response.
  - Decode error: `m_bdone`=`m_berror`=1 at t+1.
- Slave `s_bdone` at u (earliest t+2) → `s_ss`=0 and owner `m_bdone` at u+1.
- Timeout: with no `s_bdone`, `m_bdone`+`m_berror` at t+2+TIMEOUT.
- Back-to-back transactions: the owner may assert the next `m_bstart` in the cycle after its `m_bdone`.
- Handover: `breq` low at t → `m_bgnt` low at t+1; next grant earliest t+2.

## Structure
- `bus_pkg` holds `tsize_e`, `ttype_e`, `transaction` and the FSM enum `ic_state_e`; both bus interfaces import it.
- Sub-module `bus_rr_arbiter` (parameter N; ports `req`, `advance`, `gnt` one-hot, rotating pointer) encapsulates the round-robin arbitration. It is reusable elsewhere.
- Address decode and timeout counter stay inline.

## Test plan
- Single master, `SLAVE_BASE[1]`=`32'h1000_0000`, `SLAVE_MASK`=`32'hF000_0000`; write to `32'h1000_0004`, wdata `32'hDEADBEEF`, WORD → `s_ss[1]` and `s_bstart[1]` at t+1 with matching fields; slave done at t+3 → `m_bdone` at t+4, `berror`=0.
- Read from `32'hF000_0000` (no match) → `m_bdone`=`m_berror`=1 at t+1; no `s_ss` ever asserted.
- `TIMEOUT`=4, slave silent → `m_berror`+`m_bdone` at t+6; late `s_bdone` at t+8 is ignored.
- Masters 0 and 1 request continuously, each doing one transaction then dropping and re-raising `breq` → grants alternate 0,1,0,1; a `bstart` from the non-owner is ignored.
- `brst` during `ACTIVE` → all outputs 0 next cycle; then master 1 requests and is granted with no stale `m_bdone`.
- Slave `s_bdone` in the exact cycle the counter hits `TIMEOUT`, with `s_rdata`=`32'h0000_00A5` → `m_berror`=0, `m_rdata`=`32'h0000_00A5`.
